// File: rtl/edge_pulse_pkg.sv
// ----------------------------------------------------------------------------
// edge_pulse_pkg
// Shared types and helpers for the edge_pulse_bank block.
//   edge_mode_t   : edge selection (rising, falling, both, none)
//   match_edge()  : true when an accepted new level should raise a pulse
//   count_width() : width of a debounce counter able to reach cycles-1
// ----------------------------------------------------------------------------
package edge_pulse_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_t;

    function automatic logic match_edge(input edge_mode_t mode, input logic new_level);
        logic result;
        result = 1'b0;
        case (mode)
            EDGE_RISE: result = new_level;
            EDGE_FALL: result = ~new_level;
            EDGE_BOTH: result = 1'b1;
            EDGE_NONE: result = 1'b0;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

    // One extra state of headroom keeps the width at least 1 bit for cycles == 1.
    function automatic int count_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// Single-bit debouncer. All state updates on the falling edge of i_Clk.
// A new level must be seen on DEBOUNCE_CYCLES consecutive edges (after it
// has been captured into the sample register) before it becomes the stable
// level.
// Ports:
//   i_Clk     clock (falling edge active)
//   i_Rst     synchronous active-high reset; loads the current input as stable
//   i_Data    raw input level
//   o_Level   debounced (stable) level
//   o_Accept  combinational strobe: the stable level flips at the next edge
//   o_Sample  sample register, i.e. the level that is about to be accepted
// ----------------------------------------------------------------------------
module debounce_channel
    import edge_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Data,
    output logic o_Level,
    output logic o_Accept,
    output logic o_Sample
);

    localparam int CW = count_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sample_q;
    logic          level_q;
    logic [CW-1:0] count_q;

    // The strobe is combinational so the top level can register the pulse
    // on the very edge where the stable level changes.
    assign o_Accept = (sample_q != level_q) && (count_q == LAST);
    assign o_Level  = level_q;
    assign o_Sample = sample_q;

    always_ff @(negedge i_Clk) begin
        if (i_Rst) begin
            sample_q <= i_Data;
            level_q  <= i_Data;
            count_q  <= '0;
        end else begin
            sample_q <= i_Data;
            if (sample_q == level_q) begin
                count_q <= '0;
            end else if (count_q == LAST) begin
                level_q <= sample_q;
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_pulse_bank.sv
// ----------------------------------------------------------------------------
// edge_pulse_bank
// Multi-channel debounced edge-pulse generator. Each channel is debounced
// independently; when a channel's debounced level changes and the change
// matches i_Mode, a one-cycle pulse is produced. All registers update on
// the falling edge of i_Clk.
// Optional feature macro: EDGE_PULSE_BANK_LATCH_EN (adds i_Clear / o_Event).
// Ports:
//   i_Clk    clock (falling edge active)
//   i_Rst    synchronous active-high reset
//   i_Data   [CHANNELS] raw channel levels
//   i_Mode   [2] 00 rising, 01 falling, 10 both, 11 none
//   o_Pulse  [CHANNELS] one-cycle edge pulses
//   o_Level  [CHANNELS] debounced levels
//   o_Any    registered OR of the pulses, aligned with o_Pulse
//   i_Clear  [CHANNELS] (optional) clears sticky event bits
//   o_Event  [CHANNELS] (optional) sticky per-channel event flags
// ----------------------------------------------------------------------------
module edge_pulse_bank
    import edge_pulse_pkg::*;
#(
    parameter int CHANNELS        = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic [CHANNELS-1:0] i_Data,
    input  logic [1:0]          i_Mode,
    output logic [CHANNELS-1:0] o_Pulse,
    output logic [CHANNELS-1:0] o_Level,
    output logic                o_Any
`ifdef EDGE_PULSE_BANK_LATCH_EN
    ,
    input  logic [CHANNELS-1:0] i_Clear,
    output logic [CHANNELS-1:0] o_Event
`endif
);

    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] sample;
    logic [CHANNELS-1:0] next_pulse;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .i_Clk   (i_Clk),
            .i_Rst   (i_Rst),
            .i_Data  (i_Data[k]),
            .o_Level (o_Level[k]),
            .o_Accept(accept[k]),
            .o_Sample(sample[k])
        );
    end

    // Mode is only looked at on the accepting edge, so a mode change during
    // the count only affects the final decision.
    always_comb begin
        next_pulse = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            next_pulse[k] = accept[k] & match_edge(edge_mode_t'(i_Mode), sample[k]);
        end
    end

    always_ff @(negedge i_Clk) begin
        if (i_Rst) begin
            o_Pulse <= '0;
            o_Any   <= 1'b0;
        end else begin
            o_Pulse <= next_pulse;
            o_Any   <= |next_pulse;
        end
    end

`ifdef EDGE_PULSE_BANK_LATCH_EN
    // Set takes priority over clear so a pulse coinciding with a clear
    // request is never lost.
    always_ff @(negedge i_Clk) begin
        if (i_Rst) begin
            o_Event <= '0;
        end else begin
            o_Event <= (o_Event & ~i_Clear) | next_pulse;
        end
    end
`endif

endmodule

// File: tb/tb_edge_pulse_bank.sv
// ----------------------------------------------------------------------------
// tb_edge_pulse_bank
// Directed scenarios followed by randomized stimulus, compared against a
// run-length reference model of the debounce and edge rules.
// ----------------------------------------------------------------------------
module tb_edge_pulse_bank;

    localparam int CH = 8;
    localparam int DC = 4;

    logic          i_Clk;
    logic          i_Rst;
    logic [CH-1:0] i_Data;
    logic [1:0]    i_Mode;
    logic [CH-1:0] o_Pulse;
    logic [CH-1:0] o_Level;
    logic          o_Any;
`ifdef EDGE_PULSE_BANK_LATCH_EN
    logic [CH-1:0] i_Clear;
    logic [CH-1:0] o_Event;
    logic [CH-1:0] mEvent;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: the level most recently seen by the DUT's
    // sampling, the accepted level, and how many consecutive edges the seen
    // level has disagreed with the accepted one.
    logic [CH-1:0] mSeen;
    logic [CH-1:0] mLevel;
    logic [CH-1:0] mPulse;
    logic          mAny;
    int            mRun [CH];

    edge_pulse_bank #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Data (i_Data),
        .i_Mode (i_Mode),
        .o_Pulse(o_Pulse),
        .o_Level(o_Level),
        .o_Any  (o_Any)
`ifdef EDGE_PULSE_BANK_LATCH_EN
        ,
        .i_Clear(i_Clear),
        .o_Event(o_Event)
`endif
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
        end
    endtask

    function automatic logic wantPulse(input logic [1:0] mode, input logic newLevel);
        if (mode == 2'd0) return newLevel;
        if (mode == 2'd1) return !newLevel;
        if (mode == 2'd2) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one falling edge using the inputs now applied.
    task automatic modelStep(input logic [CH-1:0] data, input logic [1:0] mode, input logic rst);
        if (rst) begin
            mSeen  = data;
            mLevel = data;
            mPulse = '0;
            for (int k = 0; k < CH; k++) mRun[k] = 0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                mPulse[k] = 1'b0;
                if (mSeen[k] == mLevel[k]) begin
                    mRun[k] = 0;
                end else begin
                    mRun[k] = mRun[k] + 1;
                    if (mRun[k] == DC) begin
                        mLevel[k] = mSeen[k];
                        mRun[k]   = 0;
                        mPulse[k] = wantPulse(mode, mLevel[k]);
                    end
                end
            end
            mSeen = data;
        end
        mAny = |mPulse;
`ifdef EDGE_PULSE_BANK_LATCH_EN
        if (rst) mEvent = '0;
        else     mEvent = (mEvent & ~i_Clear) | mPulse;
`endif
    endtask

    // Drive inputs between falling edges, then compare just after the edge.
    task automatic applyStimulus(input logic [CH-1:0] data, input logic [1:0] mode, input logic rst, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(posedge i_Clk);
            i_Data = data;
            i_Mode = mode;
            i_Rst  = rst;
            modelStep(data, mode, rst);
            @(negedge i_Clk);
            #1;
            checkOutput("pulse", 32'(o_Pulse), 32'(mPulse));
            checkOutput("level", 32'(o_Level), 32'(mLevel));
            checkOutput("any",   32'(o_Any),   32'(mAny));
`ifdef EDGE_PULSE_BANK_LATCH_EN
            checkOutput("event", 32'(o_Event), 32'(mEvent));
`endif
        end
    endtask

    initial begin
        logic [CH-1:0] rdata;
        logic [1:0]    rmode;
        i_Rst  = 1'b1;
        i_Data = '0;
        i_Mode = 2'd0;
`ifdef EDGE_PULSE_BANK_LATCH_EN
        i_Clear = '0;
        mEvent  = '0;
`endif
        $display("[TB] start: CHANNELS=%0d DEBOUNCE_CYCLES=%0d", CH, DC);

        // Levels present at reset are accepted silently.
        applyStimulus(8'hA5, 2'd0, 1'b1, 1);
        applyStimulus(8'hA5, 2'd0, 1'b0, 20);

        // Rising edge on ch0, then its release.
        applyStimulus(8'h00, 2'd0, 1'b1, 1);
        applyStimulus(8'h00, 2'd0, 1'b0, 5);
        applyStimulus(8'h01, 2'd0, 1'b0, 8);
        applyStimulus(8'h00, 2'd0, 1'b0, 8);

        // Glitch of 3 samples on ch3 is rejected, 4 samples is accepted.
        applyStimulus(8'h08, 2'd0, 1'b0, 3);
        applyStimulus(8'h00, 2'd0, 1'b0, 8);
        applyStimulus(8'h08, 2'd0, 1'b0, 4);
        applyStimulus(8'h00, 2'd0, 1'b0, 10);

        // Same ch1 stimulus under both, falling and none modes.
        for (int m = 2; m >= 1; m--) begin
            applyStimulus(8'h02, 2'(m), 1'b0, 10);
            applyStimulus(8'h00, 2'(m), 1'b0, 10);
        end
        applyStimulus(8'h02, 2'd3, 1'b0, 10);
        applyStimulus(8'h00, 2'd3, 1'b0, 10);

        // All channels rise together.
        applyStimulus(8'hFF, 2'd0, 1'b0, 10);
        applyStimulus(8'h00, 2'd0, 1'b0, 10);

        // Reset mid-count discards the pending change.
        applyStimulus(8'hFF, 2'd0, 1'b0, 2);
        applyStimulus(8'hFF, 2'd0, 1'b1, 1);
        applyStimulus(8'hFF, 2'd0, 1'b0, 10);

        // Mode change during the count only matters at the accepting edge.
        applyStimulus(8'h00, 2'd3, 1'b0, 3);
        applyStimulus(8'h00, 2'd1, 1'b0, 8);

`ifdef EDGE_PULSE_BANK_LATCH_EN
        // Sticky event on ch2 with clear held, so clears coincide with pulses.
        applyStimulus(8'h04, 2'd2, 1'b0, 8);
        i_Clear = 8'h04;
        applyStimulus(8'h00, 2'd2, 1'b0, 8);
        i_Clear = 8'h00;
        applyStimulus(8'h04, 2'd2, 1'b0, 8);
`endif

        // Randomized phase: sparse bit flips so many changes survive debounce.
        rdata = o_Level;
        rmode = 2'd0;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, 5) == 0) rdata[k] = ~rdata[k];
            end
            if ($urandom_range(0, 29) == 0) rmode = 2'($urandom_range(0, 3));
`ifdef EDGE_PULSE_BANK_LATCH_EN
            i_Clear = CH'($urandom) & CH'($urandom);
`endif
            applyStimulus(rdata, rmode, ($urandom_range(0, 99) == 0), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
